bytebeat_sequencer: RTL and testbench

- Paces and sequences the bytebeat core.
- Divides clk down to a programmable sample rate. On each sample tick it issues one parameter set {a,b,c,d} to the core over its four vld/rdy input channels, then collects one PCM byte over the output channel.
- Steps through a small table of parameter slots to form a pattern, and holds the last sample on the pins.
- Sits between the top-level pin wrapper and the bytebeat core.

---
 rtl/bytebeat_seq_pkg.sv | 20 ++
 rtl/bytebeat_seq_divider.sv | 24 ++
 rtl/bytebeat_sequencer.sv | 142 ++++++++++++++
 tb/tb_bytebeat_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bytebeat_seq_pkg.sv
// bytebeat_seq_pkg: shared types and constants for the bytebeat sequencer.
package bytebeat_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        ISSUE     = 2'd2,
        WAIT_PCM  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] c;
        logic [3:0] b;
        logic [3:0] a;
    } params_t;

    localparam logic [7:0] PCM_SILENCE = 8'h80;

endpackage

// File: rtl/bytebeat_seq_divider.sv
// bytebeat_seq_divider: sample-rate tick generator, held cleared while run is low.
module bytebeat_seq_divider
    import bytebeat_seq_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick  = run && (cnt_q == div);
    assign cnt_d = (!run || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bytebeat_sequencer.sv
// bytebeat_sequencer: paces the bytebeat core from a slot table and holds the latest sample.
// Define BYTEBEAT_SEQ_UNDERRUN_CNT_EN to expose a saturating count of dropped ticks.
module bytebeat_sequencer
    import bytebeat_seq_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int DIV_W  = 16,
    parameter int STEP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic [DIV_W-1:0]         div,
    input  logic [STEP_W-1:0]        steps,
    input  logic                     cfg_we,
    input  logic [$clog2(SLOTS)-1:0] cfg_addr,
    input  logic [15:0]              cfg_data,
    output logic [3:0]               core_a,
    output logic [3:0]               core_b,
    output logic [3:0]               core_c,
    output logic [3:0]               core_d,
    output logic                     core_a_vld,
    output logic                     core_b_vld,
    output logic                     core_c_vld,
    output logic                     core_d_vld,
    input  logic                     core_a_rdy,
    input  logic                     core_b_rdy,
    input  logic                     core_c_rdy,
    input  logic                     core_d_rdy,
    input  logic [7:0]               core_pcm,
    input  logic                     core_pcm_vld,
    output logic                     core_pcm_rdy,
    output logic [7:0]               pcm_out,
    output logic                     sample_strobe,
    output logic [$clog2(SLOTS)-1:0] slot,
`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
    output logic [7:0]               underrun_cnt,
`endif
    output logic                     underrun
);

    state_e                   state_q, state_d;
    params_t                  table_q [SLOTS];
    params_t                  par_q, par_d;
    logic [3:0]               vld_q, vld_d, rdy;
    logic [$clog2(SLOTS)-1:0] slot_q, slot_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic [7:0]               pcm_q, pcm_d;
    logic                     strobe_q, tick, pcm_hs, last_step, miss;

    bytebeat_seq_divider #(.DIV_W(DIV_W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .div   (div),
        .tick  (tick)
    );

    assign rdy          = {core_d_rdy, core_c_rdy, core_b_rdy, core_a_rdy};
    assign core_pcm_rdy = (state_q == WAIT_PCM);
    assign pcm_hs       = core_pcm_rdy && core_pcm_vld;
    assign last_step    = (step_q == steps);
    assign miss         = tick && (state_q == ISSUE || state_q == WAIT_PCM);

    // A channel is done once its vld bit has dropped; ISSUE ends when all four are done.
    always_comb begin
        state_d = state_q;
        par_d   = par_q;
        vld_d   = vld_q & ~rdy;
        slot_d  = slot_q;
        step_d  = step_q;
        pcm_d   = pcm_q;
        case (state_q)
            IDLE:      state_d = run ? WAIT_TICK : IDLE;
            WAIT_TICK: begin
                if (tick) begin
                    state_d = ISSUE;
                    par_d   = table_q[slot_q];
                    vld_d   = 4'hF;
                end else if (!run) begin
                    state_d = IDLE;
                end
            end
            ISSUE:     state_d = (vld_q == 4'h0) ? WAIT_PCM : ISSUE;
            WAIT_PCM: begin
                if (pcm_hs) begin
                    pcm_d   = core_pcm;
                    step_d  = last_step ? '0 : step_q + 1'b1;
                    slot_d  = last_step ? slot_q + 1'b1 : slot_q;
                    state_d = run ? WAIT_TICK : IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            par_q    <= '0;
            vld_q    <= '0;
            slot_q   <= '0;
            step_q   <= '0;
            pcm_q    <= PCM_SILENCE;
            strobe_q <= 1'b0;
            for (int i = 0; i < SLOTS; i++) table_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            par_q    <= par_d;
            vld_q    <= vld_d;
            slot_q   <= slot_d;
            step_q   <= step_d;
            pcm_q    <= pcm_d;
            strobe_q <= pcm_hs;
            if (cfg_we) table_q[cfg_addr] <= cfg_data;
        end
    end

`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       ucnt_q <= '0;
        else if (miss && ucnt_q != 8'hFF) ucnt_q <= ucnt_q + 1'b1;
    end
    assign underrun_cnt = ucnt_q;
    assign underrun     = (ucnt_q != 8'h00);
`else
    logic under_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) under_q <= 1'b0;
        else        under_q <= under_q | miss;
    end
    assign underrun = under_q;
`endif

    assign {core_d, core_c, core_b, core_a}                 = par_q;
    assign {core_d_vld, core_c_vld, core_b_vld, core_a_vld} = vld_q;
    assign pcm_out       = pcm_q;
    assign sample_strobe = strobe_q;
    assign slot          = slot_q;

endmodule

// File: tb/tb_bytebeat_sequencer.sv
// tb_bytebeat_sequencer: vector, scripted-corner and randomized checks of the bytebeat sequencer.
// Honours BYTEBEAT_SEQ_UNDERRUN_CNT_EN to also check underrun_cnt.
module tb_bytebeat_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run, cfg_we;
    logic [15:0] div;
    logic [7:0]  steps;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [3:0]  core_a, core_b, core_c, core_d;
    logic        core_a_vld, core_b_vld, core_c_vld, core_d_vld;
    logic        core_a_rdy, core_b_rdy, core_c_rdy, core_d_rdy;
    logic [7:0]  core_pcm, pcm_out;
    logic        core_pcm_vld, core_pcm_rdy, sample_strobe, underrun;
    logic [1:0]  slot;
`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    always #5 clk = ~clk;

    bytebeat_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .div(div), .steps(steps),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .core_a_vld(core_a_vld), .core_b_vld(core_b_vld), .core_c_vld(core_c_vld), .core_d_vld(core_d_vld),
        .core_a_rdy(core_a_rdy), .core_b_rdy(core_b_rdy), .core_c_rdy(core_c_rdy), .core_d_rdy(core_d_rdy),
        .core_pcm(core_pcm), .core_pcm_vld(core_pcm_vld), .core_pcm_rdy(core_pcm_rdy),
        .pcm_out(pcm_out), .sample_strobe(sample_strobe), .slot(slot),
`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .underrun(underrun)
    );

    int checks = 0, failures = 0;

    // Core-side responder knobs (mode 0: scripted delays, mode 1: random) and captured handshakes.
    int          mode = 0, c_delay = 0, pcm_delay = 0, n_hs = 0;
    logic [7:0]  pcm_val = 8'h00, cap_pcm = 8'h00;
    logic [3:0]  cap_a = 0, cap_b = 0, cap_c = 0, cap_d = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_strobe(input int lim, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!sample_strobe && cyc < lim);
        check("strobe_seen", 32'(sample_strobe), 32'd1);
    endtask

    task automatic wait_for(input bit sel_pcm, input int lim);
        int k = 0;
        do begin @(negedge clk); k++; end while (!(sel_pcm ? core_pcm_rdy : core_c_vld) && k < lim);
        check(sel_pcm ? "pcm_rdy_seen" : "c_vld_seen", 32'(sel_pcm ? core_pcm_rdy : core_c_vld), 32'd1);
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; cfg_we = 1'b0; mode = 0; c_delay = 0; pcm_delay = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state();
        check("rst_vld", 32'({core_d_vld, core_c_vld, core_b_vld, core_a_vld}), 32'h0);
        check("rst_data", 32'({core_d, core_c, core_b, core_a}), 32'h0);
        check("rst_pcm_rdy", 32'(core_pcm_rdy), 32'h0);
        check("rst_pcm_out", 32'(pcm_out), 32'h80);
        check("rst_strobe", 32'(sample_strobe), 32'h0);
        check("rst_slot", 32'(slot), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
    endtask

    // Responder: drives the core side at each negedge and records what the next posedge will accept.
    initial begin
        logic [3:0]  pv, pr, vv;
        logic [15:0] pd, dv;
        logic        prst;
        int          c_cnt, p_cnt;
        pv = 0; pr = 0; pd = 0; prst = 0; c_cnt = 0; p_cnt = 0;
        {core_a_rdy, core_b_rdy, core_c_rdy, core_d_rdy, core_pcm_vld} = '0;
        core_pcm = 8'h00;
        forever begin
            @(negedge clk);
            vv = {core_d_vld, core_c_vld, core_b_vld, core_a_vld};
            dv = {core_d, core_c, core_b, core_a};
            for (int i = 0; i < 4; i++)
                if (prst && rst_n && pv[i] && !pr[i]) begin
                    check("hold_vld", 32'(vv[i]), 32'd1);
                    check("hold_data", 32'(dv[i*4 +: 4]), 32'(pd[i*4 +: 4]));
                end
            c_cnt = core_c_vld ? c_cnt + 1 : 0;
            p_cnt = core_pcm_rdy ? p_cnt + 1 : 0;
            if (mode == 0) begin
                {core_a_rdy, core_b_rdy, core_d_rdy} = 3'b111;
                core_c_rdy   = (c_cnt > c_delay);
                core_pcm_vld = (p_cnt > pcm_delay);
                core_pcm     = pcm_val;
            end else begin
                {core_a_rdy, core_b_rdy, core_c_rdy, core_d_rdy} = 4'($urandom);
                core_pcm_vld = ($urandom_range(0, 2) == 0);
                core_pcm     = 8'($urandom);
            end
            if (core_a_vld && core_a_rdy) cap_a = core_a;
            if (core_b_vld && core_b_rdy) cap_b = core_b;
            if (core_c_vld && core_c_rdy) cap_c = core_c;
            if (core_d_vld && core_d_rdy) cap_d = core_d;
            if (core_pcm_vld && core_pcm_rdy) begin cap_pcm = core_pcm; n_hs++; end
            pv = vv; pd = dv; prst = rst_n;
            pr = {core_d_rdy, core_c_rdy, core_b_rdy, core_a_rdy};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] div;
        logic [15:0] cfg;
        logic [7:0]  pcm;
        logic [3:0]  ea, eb, ec, ed;
        int          lat, per;
    } vec_t;

    initial begin
        vec_t        vec[4];
        int          ord[9];
        logic [15:0] tbl[4];
        int          lat, per, bad, st, base;
        vec[0] = '{div:16'd9,  cfg:16'h4321, pcm:8'h5A, ea:4'h1, eb:4'h2, ec:4'h3, ed:4'h4, lat:13, per:10};
        vec[1] = '{div:16'd3,  cfg:16'hF0A5, pcm:8'h00, ea:4'h5, eb:4'hA, ec:4'h0, ed:4'hF, lat:7,  per:4};
        vec[2] = '{div:16'd4,  cfg:16'h8C1E, pcm:8'hFF, ea:4'hE, eb:4'h1, ec:4'hC, ed:4'h8, lat:8,  per:5};
        vec[3] = '{div:16'd20, cfg:16'h7BD9, pcm:8'h01, ea:4'h9, eb:4'hD, ec:4'hB, ed:4'h7, lat:24, per:21};
        ord = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        rst_n = 1'b0; run = 1'b0; div = 16'd0; steps = 8'd0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_state();

        // Single-slot pacing vectors: first-sample latency, captured parameters, sample period.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            div = vec[i].div; steps = 8'd0; pcm_val = vec[i].pcm;
            wr(0, vec[i].cfg);
            run = 1'b1;
            wait_strobe(200, lat);
            check("vec_latency", 32'(lat), 32'(vec[i].lat));
            check("vec_params", 32'({cap_d, cap_c, cap_b, cap_a}), 32'({vec[i].ed, vec[i].ec, vec[i].eb, vec[i].ea}));
            check("vec_pcm_out", 32'(pcm_out), 32'(vec[i].pcm));
            check("vec_slot", 32'(slot), 32'd1);
            wait_strobe(200, per);
            check("vec_period", 32'(per), 32'(vec[i].per));
            check("vec_underrun", 32'(underrun), 32'd0);
        end

        // Slot sequencing with two samples per slot.
        do_reset();
        div = 16'd5; steps = 8'd1; pcm_val = 8'h11;
        for (int i = 0; i < 4; i++) wr(i, 16'h1111 * 16'(i + 1));
        run = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wait_strobe(100, per);
            check("slot_order", 32'(cap_a), 32'(ord[k] + 1));
        end

        // Channel c stalls for five cycles while a, b, d complete immediately.
        do_reset();
        div = 16'd19; steps = 8'd0; pcm_val = 8'h3C; c_delay = 5;
        wr(0, 16'h9A5C);
        run = 1'b1;
        wait_for(1'b0, 60);
        check("stall_all_vld", 32'({core_d_vld, core_c_vld, core_b_vld, core_a_vld}), 32'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_vld", 32'({core_d_vld, core_c_vld, core_b_vld, core_a_vld}), 32'h4);
            check("stall_c", 32'(core_c), 32'hA);
            check("stall_no_pcm", 32'(core_pcm_rdy), 32'd0);
        end
        @(negedge clk);
        check("stall_done_vld", 32'({core_d_vld, core_c_vld, core_b_vld, core_a_vld}), 32'h0);
        check("stall_done_no_pcm", 32'(core_pcm_rdy), 32'd0);
        @(negedge clk);
        check("stall_pcm_phase", 32'(core_pcm_rdy), 32'd1);
        wait_strobe(10, per);
        check("stall_pcm_out", 32'(pcm_out), 32'h3C);
        check("stall_cap", 32'({cap_d, cap_c, cap_b, cap_a}), 32'h9A5C);

        // Run dropped during WAIT_PCM: sample completes, FSM idles, resumes at retained slot.
        do_reset();
        div = 16'd9; steps = 8'd0; pcm_val = 8'hC3; pcm_delay = 3;
        for (int i = 0; i < 4; i++) wr(i, 16'h1111 * 16'(i + 1));
        run = 1'b1;
        wait_for(1'b1, 40);
        run = 1'b0;
        wait_strobe(20, per);
        check("stop_pcm_out", 32'(pcm_out), 32'hC3);
        check("stop_cap_a", 32'(cap_a), 32'd1);
        check("stop_slot", 32'(slot), 32'd1);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (core_a_vld || core_b_vld || core_c_vld || core_d_vld || core_pcm_rdy || sample_strobe) bad++;
        end
        check("stop_idle", 32'(bad), 32'd0);
        run = 1'b1;
        wait_strobe(60, per);
        check("resume_cap_a", 32'(cap_a), 32'd2);
        check("resume_slot", 32'(slot), 32'd2);

        // Randomized: random table, steps, core timing; expected slot is floor(n/(steps+1)) mod SLOTS.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            steps = 8'($urandom_range(0, 3)); div = 16'($urandom_range(3, 12));
            for (int i = 0; i < 4; i++) begin tbl[i] = 16'($urandom); wr(i, tbl[i]); end
            st = int'(steps) + 1; base = n_hs;
            mode = 1; run = 1'b1;
            for (int n = 0; n < 40; n++) begin
                wait_strobe(500, per);
                check("rand_params", 32'({cap_d, cap_c, cap_b, cap_a}), 32'(tbl[(n / st) % 4]));
                check("rand_pcm_out", 32'(pcm_out), 32'(cap_pcm));
                check("rand_slot", 32'(slot), 32'(((n + 1) / st) % 4));
                check("rand_count", 32'(n_hs - base), 32'(n + 1));
            end
        end

        // Underrun: div=1 with pcm_vld delayed 6 cycles drops four ticks per sample.
        do_reset();
        div = 16'd1; steps = 8'd0; pcm_val = 8'h77; pcm_delay = 6;
        wr(0, 16'h1234);
        check("ur_initial", 32'(underrun), 32'd0);
        run = 1'b1;
        wait_strobe(40, lat);
        check("ur_latency", 32'(lat), 32'd11);
        check("ur_flag1", 32'(underrun), 32'd1);
`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
        check("ur_cnt1", 32'(underrun_cnt), 32'd4);
`endif
        wait_strobe(40, per);
        check("ur_period", 32'(per), 32'd10);
        check("ur_flag2", 32'(underrun), 32'd1);
`ifdef BYTEBEAT_SEQ_UNDERRUN_CNT_EN
        check("ur_cnt2", 32'(underrun_cnt), 32'd8);
`endif

        // Asynchronous reset in the middle of an ISSUE.
        c_delay = 5;
        wait_for(1'b0, 40);
        #2 rst_n = 1'b0;
        #1 check("async_rst_vld", 32'({core_d_vld, core_c_vld, core_b_vld, core_a_vld}), 32'h0);
        run = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_state();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
